// File: rtl/mem_stage.sv
// Purpose : pipeline MEM stage; serialises loads/stores into byte accesses on a byte-wide memory controller.
// Latency : NOP-class ops pass through combinationally; memory ops take 1 + sum(per-byte cycles) + 1 cycles.
// Backpressure: stall_req holds IF..EX_MEM while an access is in flight; rdy=0 freezes all state.
//
// Ports: clk/rst (async active-low)/rdy; in_* from EX_MEM; wb_* to MEM_WB;
//        mc_* byte-wide memory controller handshake (mc_done = byte finished this cycle);
//        stall_req to the stall controller.
// Optional: define MEM_STAGE_FWD_EN to add fwd_valid/fwd_rd/fwd_data (copies of wb_*) for ID forwarding.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    input  logic        in_w_enable,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_w_enable,
    output logic        mc_req,
    output logic        mc_we,
    output logic [31:0] mc_addr,
    output logic [7:0]  mc_wdata,
    input  logic [7:0]  mc_rdata,
    input  logic        mc_done,
    output logic        stall_req
`ifdef MEM_STAGE_FWD_EN
    ,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    // Index of the final byte of an access (byte count - 1).
    function automatic logic [1:0] last_idx(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 2'd0;
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            default:              return 2'd3;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] buf_q, buf_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] load_result;

    // Next-state logic; with rdy low every register simply holds.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (is_load(in_op) || is_store(in_op)) begin
                        state_d = ACCESS;
                        op_d    = in_op;
                        addr_d  = in_addr;
                        wdata_d = in_wdata;
                        rd_d    = in_rd;
                        idx_d   = 2'd0;
                        buf_d   = 32'd0;
                    end
                end
                ACCESS: begin
                    if (mc_done) begin
                        if (is_load(op_q)) begin
                            buf_d[{idx_q, 3'b000} +: 8] = mc_rdata;
                        end
                        if (idx_q == last_idx(op_q)) begin
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            buf_q   <= 32'd0;
            op_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
        end
    end

    // Extension of the assembled load buffer; stores write back nothing.
    always_comb begin
        case (op_q)
            OP_LB:   load_result = {{24{buf_q[7]}}, buf_q[7:0]};
            OP_LH:   load_result = {{16{buf_q[15]}}, buf_q[15:0]};
            OP_LW:   load_result = buf_q;
            OP_LBU:  load_result = {24'd0, buf_q[7:0]};
            OP_LHU:  load_result = {16'd0, buf_q[15:0]};
            default: load_result = 32'd0;
        endcase
    end

    // Outputs decode the current state; rst is folded in so the pass-through
    // path is also silenced while reset is asserted.
    always_comb begin
        wb_rd       = 5'd0;
        wb_data     = 32'd0;
        wb_w_enable = 1'b0;
        mc_req      = 1'b0;
        mc_we       = 1'b0;
        mc_addr     = 32'd0;
        mc_wdata    = 8'd0;
        stall_req   = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (is_load(in_op) || is_store(in_op)) begin
                        stall_req = 1'b1;
                    end else begin
                        wb_rd       = in_rd;
                        wb_data     = in_wdata;
                        wb_w_enable = in_w_enable && (in_rd != 5'd0);
                    end
                end
                ACCESS: begin
                    stall_req = 1'b1;
                    mc_req    = 1'b1;
                    mc_we     = is_store(op_q);
                    mc_addr   = addr_q + {30'd0, idx_q};
                    mc_wdata  = wdata_q[{idx_q, 3'b000} +: 8];
                end
                DONE: begin
                    wb_rd       = rd_q;
                    wb_data     = load_result;
                    wb_w_enable = is_load(op_q) && (rd_q != 5'd0);
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_STAGE_FWD_EN
    assign fwd_valid = wb_w_enable;
    assign fwd_rd    = wb_rd;
    assign fwd_data  = wb_data;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Purpose : directed self-checking bench for mem_stage.
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled 1 unit later.
// Backpressure: memory controller modelled with a per-byte mc_done delay and an optional rdy freeze.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        in_w_enable;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_w_enable;
    logic        mc_req;
    logic        mc_we;
    logic [31:0] mc_addr;
    logic [7:0]  mc_wdata;
    logic [7:0]  mc_rdata;
    logic        mc_done;
    logic        stall_req;
`ifdef MEM_STAGE_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    always #5 clk = ~clk;

    mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .in_op       (in_op),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_rd       (in_rd),
        .in_w_enable (in_w_enable),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_w_enable (wb_w_enable),
        .mc_req      (mc_req),
        .mc_we       (mc_we),
        .mc_addr     (mc_addr),
        .mc_wdata    (mc_wdata),
        .mc_rdata    (mc_rdata),
        .mc_done     (mc_done),
        .stall_req   (stall_req)
`ifdef MEM_STAGE_FWD_EN
        ,
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data)
`endif
    );

    int total_n = 0;
    int bad_n   = 0;

    // Observations collected by the driver for one memory op.
    logic [31:0] o_data;
    logic        o_we;
    logic [4:0]  o_rd;
    int          o_total;
    int          o_stall;
    int          o_nb;
    int          o_frz_bad;
    logic        o_we_pre;
    logic        o_timeout;
    logic [31:0] o_addr [4];
    logic [7:0]  o_wd   [4];
    logic        o_mcwe [4];

    // Drives one memory op, answers bytes from rdata (little-endian) after
    // 'delay' waiting cycles each, and optionally drops rdy for 3 cycles at
    // ACCESS cycle number freeze_at. Starts and ends 1 unit after a rising edge.
    task automatic do_mem(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd,
                          input logic [31:0] rdata, input int delay, input int freeze_at);
        int hold = 0;
        int acc  = 0;
        int frz  = 0;
        bit fin  = 0;
        bit frz_used = 0;
        logic [31:0] frz_addr = 32'd0;
        o_data = 32'hx; o_we = 1'bx; o_rd = 5'hx;
        o_total = 0; o_stall = 0; o_nb = 0; o_frz_bad = 0;
        o_we_pre = 1'b0; o_timeout = 1'b0;
        for (int i = 0; i < 4; i++) begin
            o_addr[i] = 32'hx; o_wd[i] = 8'hx; o_mcwe[i] = 1'bx;
        end
        in_op = op; in_addr = addr; in_wdata = wdata; in_rd = rd; in_w_enable = 1'b1;
        mc_done = 1'b0; rdy = 1'b1;
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            #1;
            if (stall_req) o_stall++;
            if (mc_req) begin
                if (wb_w_enable) o_we_pre = 1'b1;
                if (frz > 0) begin
                    rdy = 1'b0; mc_done = 1'b0;
                    if (mc_addr !== frz_addr) o_frz_bad++;
                    frz--;
                end else if (!frz_used && acc == freeze_at) begin
                    frz_used = 1; frz_addr = mc_addr; frz = 2;
                    rdy = 1'b0; mc_done = 1'b0;
                end else begin
                    rdy = 1'b1;
                    if (hold == delay) begin
                        mc_done  = 1'b1;
                        mc_rdata = 8'(rdata >> (8 * o_nb));
                        if (o_nb < 4) begin
                            o_addr[o_nb] = mc_addr;
                            o_wd[o_nb]   = mc_wdata;
                            o_mcwe[o_nb] = mc_we;
                        end
                        o_nb++;
                        hold = 0;
                    end else begin
                        mc_done = 1'b0;
                        hold++;
                    end
                end
                acc++;
            end else if (cyc > 0 && !stall_req) begin
                o_data = wb_data; o_we = wb_w_enable; o_rd = wb_rd;
                fin = 1; mc_done = 1'b0;
            end else begin
                if (wb_w_enable) o_we_pre = 1'b1;
                mc_done = 1'b0;
            end
            o_total = cyc + 1;
            if (!fin) begin
                @(posedge clk); #1;
                if (cyc == 0) begin
                    // Garbage on in_* while busy must be ignored.
                    in_op = 4'd3; in_addr = 32'h5555_0000; in_wdata = 32'h0BAD_0BAD;
                    in_rd = 5'd9; in_w_enable = 1'b1;
                end
            end
        end
        if (!fin) o_timeout = 1'b1;
        in_op = 4'd0; in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0; in_w_enable = 1'b0;
        rdy = 1'b1; mc_done = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; mc_done = 1'b1; mc_rdata = 8'hA5;
        in_op = 4'd0; in_addr = 32'h10; in_wdata = 32'h1111_2222; in_rd = 5'd3; in_w_enable = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        total_n++; if (wb_data !== 32'd0) begin bad_n++; $display("FAIL rst_wb_data got=%h want=%h", wb_data, 32'd0); end
        total_n++; if (wb_w_enable !== 1'b0) begin bad_n++; $display("FAIL rst_wb_we got=%b want=0", wb_w_enable); end
        total_n++; if (wb_rd !== 5'd0) begin bad_n++; $display("FAIL rst_wb_rd got=%h want=0", wb_rd); end
        total_n++; if ({mc_req, mc_we, stall_req} !== 3'b000) begin bad_n++; $display("FAIL rst_ctrl got=%b want=000", {mc_req, mc_we, stall_req}); end
        total_n++; if (mc_addr !== 32'd0) begin bad_n++; $display("FAIL rst_mc_addr got=%h want=0", mc_addr); end
        @(posedge clk); #1;
        rst = 1'b1; mc_done = 1'b0;
        in_op = 4'd0; in_w_enable = 1'b0; in_rd = 5'd0;
    endtask

    task automatic test_nop();
        in_op = 4'd0; in_wdata = 32'h1234_5678; in_rd = 5'd5; in_w_enable = 1'b1; mc_done = 1'b1;
        #1;
        total_n++; if (wb_data !== 32'h1234_5678) begin bad_n++; $display("FAIL nop_data got=%h want=%h", wb_data, 32'h1234_5678); end
        total_n++; if (wb_rd !== 5'd5) begin bad_n++; $display("FAIL nop_rd got=%0d want=5", wb_rd); end
        total_n++; if (wb_w_enable !== 1'b1) begin bad_n++; $display("FAIL nop_we got=%b want=1", wb_w_enable); end
        total_n++; if ({stall_req, mc_req} !== 2'b00) begin bad_n++; $display("FAIL nop_stall got=%b want=00", {stall_req, mc_req}); end
        in_rd = 5'd0; #1;
        total_n++; if (wb_w_enable !== 1'b0) begin bad_n++; $display("FAIL nop_rd0_we got=%b want=0", wb_w_enable); end
        in_op = 4'd12; in_wdata = 32'hDEAD_BEEF; in_rd = 5'd9;
        @(posedge clk); #2;
        total_n++; if (wb_data !== 32'hDEAD_BEEF) begin bad_n++; $display("FAIL op12_data got=%h want=%h", wb_data, 32'hDEAD_BEEF); end
        total_n++; if ({stall_req, mc_req, wb_w_enable} !== 3'b001) begin bad_n++; $display("FAIL op12_ctrl got=%b want=001", {stall_req, mc_req, wb_w_enable}); end
        mc_done = 1'b0; in_op = 4'd0; in_w_enable = 1'b0; in_rd = 5'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        do_mem(4'd3, 32'h100, 32'd0, 5'd3, 32'h1234_5678, 0, -1);
        total_n++; if (o_timeout !== 1'b0) begin bad_n++; $display("FAIL lw_timeout got=%b want=0", o_timeout); end
        total_n++; if (o_data !== 32'h1234_5678) begin bad_n++; $display("FAIL lw_data got=%h want=%h", o_data, 32'h1234_5678); end
        total_n++; if ({o_we, o_rd} !== {1'b1, 5'd3}) begin bad_n++; $display("FAIL lw_we_rd got=%b/%0d want=1/3", o_we, o_rd); end
        total_n++; if (o_total !== 6) begin bad_n++; $display("FAIL lw_cycles got=%0d want=6", o_total); end
        total_n++; if (o_stall !== 5) begin bad_n++; $display("FAIL lw_stall got=%0d want=5", o_stall); end
        total_n++; if (o_we_pre !== 1'b0) begin bad_n++; $display("FAIL lw_we_early got=%b want=0", o_we_pre); end
        for (int i = 0; i < 4; i++) begin
            total_n++;
            if (o_addr[i] !== 32'h100 + 32'(i) || o_mcwe[i] !== 1'b0) begin
                bad_n++; $display("FAIL lw_addr%0d got=%h/we%b want=%h/we0", i, o_addr[i], o_mcwe[i], 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_sign_ext();
        do_mem(4'd1, 32'h40, 32'd0, 5'd1, 32'h0000_0080, 0, -1);
        total_n++; if (o_data !== 32'hFFFF_FF80) begin bad_n++; $display("FAIL lb_data got=%h want=%h", o_data, 32'hFFFF_FF80); end
        total_n++; if (o_total !== 3) begin bad_n++; $display("FAIL lb_cycles got=%0d want=3", o_total); end
        do_mem(4'd4, 32'h40, 32'd0, 5'd1, 32'h0000_0080, 0, -1);
        total_n++; if (o_data !== 32'h0000_0080) begin bad_n++; $display("FAIL lbu_data got=%h want=%h", o_data, 32'h0000_0080); end
        do_mem(4'd2, 32'h50, 32'd0, 5'd2, 32'h0000_8001, 0, -1);
        total_n++; if (o_data !== 32'hFFFF_8001) begin bad_n++; $display("FAIL lh_data got=%h want=%h", o_data, 32'hFFFF_8001); end
        total_n++; if (o_total !== 4) begin bad_n++; $display("FAIL lh_cycles got=%0d want=4", o_total); end
        do_mem(4'd5, 32'h50, 32'd0, 5'd2, 32'h0000_8001, 1, -1);
        total_n++; if (o_data !== 32'h0000_8001) begin bad_n++; $display("FAIL lhu_data got=%h want=%h", o_data, 32'h0000_8001); end
    endtask

    task automatic test_sh_wrap();
        do_mem(4'd7, 32'hFFFF_FFFF, 32'hAABB_CCDD, 5'd4, 32'd0, 2, -1);
        total_n++; if (o_nb !== 2) begin bad_n++; $display("FAIL sh_bytes got=%0d want=2", o_nb); end
        total_n++; if (o_addr[0] !== 32'hFFFF_FFFF || o_wd[0] !== 8'hDD || o_mcwe[0] !== 1'b1) begin
            bad_n++; $display("FAIL sh_b0 got=%h@%h we%b want=dd@ffffffff we1", o_wd[0], o_addr[0], o_mcwe[0]); end
        total_n++; if (o_addr[1] !== 32'h0 || o_wd[1] !== 8'hCC || o_mcwe[1] !== 1'b1) begin
            bad_n++; $display("FAIL sh_b1 got=%h@%h we%b want=cc@00000000 we1", o_wd[1], o_addr[1], o_mcwe[1]); end
        total_n++; if ({o_we, o_we_pre} !== 2'b00) begin bad_n++; $display("FAIL sh_we got=%b want=00", {o_we, o_we_pre}); end
        total_n++; if (o_data !== 32'd0) begin bad_n++; $display("FAIL sh_data got=%h want=0", o_data); end
        total_n++; if (o_total !== 8) begin bad_n++; $display("FAIL sh_cycles got=%0d want=8", o_total); end
    endtask

    task automatic test_reset_mid();
        in_op = 4'd3; in_addr = 32'h300; in_rd = 5'd2; in_w_enable = 1'b1; rdy = 1'b1; mc_done = 1'b0;
        @(posedge clk); #1;
        mc_done = 1'b1; mc_rdata = 8'h11;
        repeat (2) begin @(posedge clk); #1; end
        #1;
        total_n++; if ({mc_req, stall_req} !== 2'b11 || mc_addr !== 32'h302) begin
            bad_n++; $display("FAIL mid_pre got=%b/%h want=11/00000302", {mc_req, stall_req}, mc_addr); end
        rst = 1'b0;
        in_op = 4'd0; in_wdata = 32'hCAFE_BABE; in_rd = 5'd7;
        #1;
        total_n++; if ({mc_req, stall_req, mc_we} !== 3'b000) begin bad_n++; $display("FAIL mid_rst_ctrl got=%b want=000", {mc_req, stall_req, mc_we}); end
        total_n++; if (mc_addr !== 32'd0 || wb_data !== 32'd0 || wb_w_enable !== 1'b0) begin
            bad_n++; $display("FAIL mid_rst_out got=%h/%h/%b want=0/0/0", mc_addr, wb_data, wb_w_enable); end
        @(posedge clk); #1;
        rst = 1'b1; mc_done = 1'b0;
        #1;
        total_n++; if (wb_data !== 32'hCAFE_BABE || wb_rd !== 5'd7 || wb_w_enable !== 1'b1) begin
            bad_n++; $display("FAIL mid_nop got=%h/%0d/%b want=cafebabe/7/1", wb_data, wb_rd, wb_w_enable); end
        @(posedge clk); #2;
        total_n++; if ({mc_req, stall_req} !== 2'b00) begin bad_n++; $display("FAIL mid_resume got=%b want=00", {mc_req, stall_req}); end
        in_w_enable = 1'b0; in_rd = 5'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_freeze();
        do_mem(4'd3, 32'h200, 32'd0, 5'd0, 32'hCAFE_F00D, 0, 2);
        total_n++; if (o_frz_bad !== 0) begin bad_n++; $display("FAIL frz_addr got=%0d moves want=0", o_frz_bad); end
        total_n++; if (o_total !== 9) begin bad_n++; $display("FAIL frz_cycles got=%0d want=9", o_total); end
        total_n++; if (o_addr[2] !== 32'h202 || o_addr[3] !== 32'h203) begin
            bad_n++; $display("FAIL frz_tail got=%h,%h want=00000202,00000203", o_addr[2], o_addr[3]); end
        total_n++; if ({o_we, o_we_pre} !== 2'b00) begin bad_n++; $display("FAIL frz_we got=%b want=00", {o_we, o_we_pre}); end
        total_n++; if (o_data !== 32'hCAFE_F00D) begin bad_n++; $display("FAIL frz_data got=%h want=%h", o_data, 32'hCAFE_F00D); end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_lw();
        test_sign_ext();
        test_sh_wrap();
        test_reset_mid();
        test_freeze();
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
